// File: rtl/contrast_adjust_pipe_pkg.sv
// Shared defaults, stage-control struct and width/constant helpers for the
// contrast pipeline.
package contrast_adjust_pipe_pkg;

  localparam int CH_W_DEF      = 8;
  localparam int NUM_CH_DEF    = 3;
  localparam int GAIN_W_DEF    = 8;
  localparam int GAIN_FRAC_DEF = 4;
  localparam int GAIN_STEP_DEF = 2;
  localparam int GAIN_MIN_DEF  = 0;
  localparam int GAIN_MAX_DEF  = 64;

  typedef struct packed {
    logic valid;
    logic en;
  } stage_ctl_t;

  function automatic int mid_of(input int ch_w);
    return 1 << (ch_w - 1);
  endfunction

  function automatic int unity_of(input int gain_frac);
    return 1 << gain_frac;
  endfunction

  function automatic int round_k_of(input int gain_frac);
    return (gain_frac > 0) ? (1 << (gain_frac - 1)) : 0;
  endfunction

  // Signed product width: (CH_W+1)-bit difference times zero-extended gain.
  function automatic int prod_w_of(input int ch_w, input int gain_w);
    return ch_w + 1 + gain_w;
  endfunction

endpackage

// File: rtl/contrast_adjust_pipe_lane.sv
// One channel of the contrast datapath: centre on MID, multiply by gain,
// round half up, re-centre and clamp; bypass passes the raw pixel through.
module contrast_adjust_pipe_lane
  import contrast_adjust_pipe_pkg::*;
#(
  parameter int CH_W      = CH_W_DEF,
  parameter int GAIN_W    = GAIN_W_DEF,
  parameter int GAIN_FRAC = GAIN_FRAC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH_W-1:0]   pix_in,
  input  logic [GAIN_W-1:0] gain_s1,
  input  logic              valid_s2,
  input  logic              bypass_s2,
  output logic [CH_W-1:0]   pix_out
);

  localparam int PW = prod_w_of(CH_W, GAIN_W);
  localparam logic signed [CH_W:0] MID_D   = (CH_W+1)'(mid_of(CH_W));
  localparam logic signed [PW-1:0] MID_X   = PW'(mid_of(CH_W));
  localparam logic signed [PW-1:0] ROUND_X = PW'(round_k_of(GAIN_FRAC));
  localparam logic signed [PW-1:0] TOP_X   = PW'((1 << CH_W) - 1);

  logic [CH_W-1:0]        raw_s1, raw_s2;
  logic signed [CH_W:0]   diff_s1;
  logic signed [PW-1:0]   diff_x, gain_x, prod_s2;
  logic signed [PW-1:0]   rounded, level;
  logic [CH_W-1:0]        clamped;

  always_ff @(posedge clk) begin
    raw_s1  <= pix_in;
    diff_s1 <= $signed({1'b0, pix_in}) - MID_D;
    raw_s2  <= raw_s1;
    prod_s2 <= diff_x * gain_x;
  end

  // Both operands widened to the full product width so the multiply is exact.
  always_comb begin
    diff_x = PW'(diff_s1);
    gain_x = $signed(PW'({1'b0, gain_s1}));
  end

  always_comb begin
    rounded = (prod_s2 + ROUND_X) >>> GAIN_FRAC;
    level   = rounded + MID_X;
    if (level[PW-1])
      clamped = '0;
    else if (level > TOP_X)
      clamped = '1;
    else
      clamped = level[CH_W-1:0];
  end

  // Output holds its last value between valid pixels.
  always_ff @(posedge clk) begin
    if (rst)
      pix_out <= '0;
    else if (valid_s2)
      pix_out <= bypass_s2 ? raw_s2 : clamped;
  end

endmodule

// File: rtl/contrast_adjust_pipe.sv
// Pipelined contrast stage: strobe-stepped pending gain, frame-committed
// active gain, and a fixed 3-cycle valid/enable/gain-snapshot pipeline.
module contrast_adjust_pipe
  import contrast_adjust_pipe_pkg::*;
#(
  parameter int CH_W      = CH_W_DEF,
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int GAIN_W    = GAIN_W_DEF,
  parameter int GAIN_FRAC = GAIN_FRAC_DEF,
  parameter int GAIN_STEP = GAIN_STEP_DEF,
  parameter int GAIN_MIN  = GAIN_MIN_DEF,
  parameter int GAIN_MAX  = GAIN_MAX_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     frame_en,
  input  logic                     inc,
  input  logic                     dec,
  input  logic                     in_valid,
  input  logic [NUM_CH*CH_W-1:0]   pix_in,
  output logic                     out_valid,
  output logic [NUM_CH*CH_W-1:0]   pix_out,
  output logic [GAIN_W-1:0]        gain_level
);

  localparam logic [GAIN_W-1:0] UNITY  = GAIN_W'(unity_of(GAIN_FRAC));
  localparam logic [GAIN_W-1:0] GSTEP  = GAIN_W'(GAIN_STEP);
  localparam logic [GAIN_W-1:0] GMIN   = GAIN_W'(GAIN_MIN);
  localparam logic [GAIN_W-1:0] GMAX   = GAIN_W'(GAIN_MAX);
  localparam logic [GAIN_W:0]   STEP_X = (GAIN_W+1)'(GAIN_STEP);
  localparam logic [GAIN_W:0]   MIN_X  = (GAIN_W+1)'(GAIN_MIN);
  localparam logic [GAIN_W:0]   MAX_X  = (GAIN_W+1)'(GAIN_MAX);

  logic              inc_q, dec_q, inc_ev, dec_ev;
  logic [GAIN_W-1:0] gain_pend, gain_act, gain_s1;
  logic [GAIN_W-1:0] gain_up, gain_dn;
  logic [GAIN_W:0]   pend_x, up_x;
  stage_ctl_t        ctl_s1, ctl_s2;
  logic              valid_s3;

  assign inc_ev = inc & ~inc_q;
  assign dec_ev = dec & ~dec_q;

  // One extra bit so the saturation tests cannot wrap.
  always_comb begin
    pend_x  = {1'b0, gain_pend};
    up_x    = pend_x + STEP_X;
    gain_up = (up_x > MAX_X) ? GMAX : up_x[GAIN_W-1:0];
    gain_dn = (pend_x < MIN_X + STEP_X) ? GMIN : gain_pend - GSTEP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      gain_pend <= UNITY;
      gain_act  <= UNITY;
    end else begin
      inc_q <= inc;
      dec_q <= dec;
      // Commit takes the pre-step pending value; a same-cycle step stays pending.
      if (frame_en)
        gain_act <= gain_pend;
      if (inc_ev && !dec_ev)
        gain_pend <= gain_up;
      else if (dec_ev && !inc_ev)
        gain_pend <= gain_dn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_s1   <= '0;
      ctl_s2   <= '0;
      valid_s3 <= 1'b0;
      gain_s1  <= UNITY;
    end else begin
      ctl_s1   <= '{valid: in_valid, en: enable};
      ctl_s2   <= ctl_s1;
      valid_s3 <= ctl_s2.valid;
      gain_s1  <= gain_act;
    end
  end

  assign out_valid  = valid_s3;
  assign gain_level = gain_act;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    contrast_adjust_pipe_lane #(
      .CH_W      (CH_W),
      .GAIN_W    (GAIN_W),
      .GAIN_FRAC (GAIN_FRAC)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .pix_in    (pix_in[c*CH_W +: CH_W]),
      .gain_s1   (gain_s1),
      .valid_s2  (ctl_s2.valid),
      .bypass_s2 (~ctl_s2.en),
      .pix_out   (pix_out[c*CH_W +: CH_W])
    );
  end

endmodule
